// File: rtl/singleport_bram_bytewe_multimode_pkg.sv
// singleport_bram_bytewe_multimode_pkg: write-mode constants and clear FSM encoding.
package singleport_bram_bytewe_multimode_pkg;
    localparam int WM_NO_CHANGE   = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_WRITE_FIRST = 2;
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;
endpackage

// File: rtl/singleport_bram_bytewe_multimode_lane.sv
// bram_byte_lane: one byte lane of storage with a registered, mode-dependent read port.
module bram_byte_lane
    import singleport_bram_bytewe_multimode_pkg::*;
#(
    parameter int DEPTH      = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int BYTE_WIDTH = 8,
    parameter int WRITE_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic                  rd_i,
    input  logic                  zero_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [BYTE_WIDTH-1:0] din_i,
    output logic [BYTE_WIDTH-1:0] dout_o
);
    logic [BYTE_WIDTH-1:0] mem_q [DEPTH];
    logic [BYTE_WIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= din_i;
    end

    // Non-blocking array read sees the pre-write word, giving read-first by default.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rd_q <= '0;
        else if (rd_i) rd_q <= zero_i ? '0 : (WRITE_MODE == WM_WRITE_FIRST && we_i) ? din_i : mem_q[addr_i];
    end

    assign dout_o = rd_q;
endmodule

// File: rtl/singleport_bram_bytewe_multimode.sv
// singleport_bram_bytewe_multimode: single-port byte-write RAM with selectable write mode,
// optional output register and a zero-fill sequence after reset.
module singleport_bram_bytewe_multimode
    import singleport_bram_bytewe_multimode_pkg::*;
#(
    parameter int DEPTH          = 512,
    parameter int ADDR_WIDTH     = 9,
    parameter int BYTE_WIDTH     = 8,
    parameter int NUM_BYTES      = 2,
    parameter int WRITE_MODE     = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            en,
    input  logic [NUM_BYTES-1:0]            we,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [NUM_BYTES*BYTE_WIDTH-1:0] DI,
    output logic [NUM_BYTES*BYTE_WIDTH-1:0] DO,
    output logic                            DO_valid,
    output logic                            busy
);
    localparam int W = NUM_BYTES * BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  acc, in_range, rd_upd, v1_q;
    logic [W-1:0]          rd_w;

    assign busy     = state_q == ST_CLEAR;
    assign acc      = en && !busy;
    assign in_range = 32'(addr) < DEPTH;
    assign rd_upd   = acc && (we == '0 || WRITE_MODE != WM_NO_CHANGE);

    always_comb begin
        state_d = (busy && cnt_q == LAST) ? ST_IDLE : state_q;
        cnt_d   = busy ? ((cnt_q == LAST) ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v1_q    <= rd_upd;
        end
    end

    // While clearing, every lane is steered to write zero at the clear counter.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
        bram_byte_lane #(
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .BYTE_WIDTH(BYTE_WIDTH),
            .WRITE_MODE(WRITE_MODE)
        ) u_lane (
            .clk_i (CLK),
            .rst_i (RST),
            .we_i  (busy || (acc && we[i] && in_range)),
            .rd_i  (rd_upd),
            .zero_i(!in_range),
            .addr_i(busy ? cnt_q : addr),
            .din_i (busy ? '0 : DI[i*BYTE_WIDTH +: BYTE_WIDTH]),
            .dout_o(rd_w[i*BYTE_WIDTH +: BYTE_WIDTH])
        );
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [W-1:0] do_q;
        logic         v2_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                do_q <= '0;
                v2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) do_q <= rd_w;
            end
        end
        assign DO       = do_q;
        assign DO_valid = v2_q;
    end else begin : g_direct
        assign DO       = rd_w;
        assign DO_valid = v1_q;
    end
endmodule

// File: tb/tb_singleport_bram_bytewe_multimode.sv
// tb_singleport_bram_bytewe_multimode: three configurations driven in lockstep, with outputs
// checked against a reference memory model through a timestamped scoreboard.
module tb_singleport_bram_bytewe_multimode;
    typedef struct packed {
        int          id;
        int          t;
        logic [31:0] v;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic [3:0]  we;
    logic [8:0]  addr;
    logic [31:0] DI;
    logic [15:0] do_a, do_b;
    logic [31:0] do_c;
    logic        vld_a, vld_b, vld_c, busy_a, busy_b, busy_c;
    logic [31:0] dout [3];
    logic        vld [3];

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] mdl [3][512];
    exp_t        sb [$];

    singleport_bram_bytewe_multimode u_a (
        .CLK(CLK), .RST(RST), .en(en), .we(we[1:0]), .addr(addr), .DI(DI[15:0]),
        .DO(do_a), .DO_valid(vld_a), .busy(busy_a)
    );
    singleport_bram_bytewe_multimode #(.WRITE_MODE(1), .OUT_REG(1)) u_b (
        .CLK(CLK), .RST(RST), .en(en), .we(we[1:0]), .addr(addr), .DI(DI[15:0]),
        .DO(do_b), .DO_valid(vld_b), .busy(busy_b)
    );
    singleport_bram_bytewe_multimode #(.DEPTH(300), .NUM_BYTES(4), .WRITE_MODE(2)) u_c (
        .CLK(CLK), .RST(RST), .en(en), .we(we), .addr(addr), .DI(DI),
        .DO(do_c), .DO_valid(vld_c), .busy(busy_c)
    );

    assign dout[0] = {16'h0, do_a};
    assign dout[1] = {16'h0, do_b};
    assign dout[2] = do_c;
    assign vld[0]  = vld_a;
    assign vld[1]  = vld_b;
    assign vld[2]  = vld_c;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic zero_model();
        for (int d = 0; d < 3; d++)
            for (int j = 0; j < 512; j++) mdl[d][j] = 32'h0;
    endtask

    // Drives one cycle of stimulus and pushes each configuration's expected output.
    task automatic acc(input logic e, input logic [3:0] w, input logic [8:0] a, input logic [31:0] di);
        @(negedge CLK);
        en = e; we = w; addr = a; DI = di;
        if (e) for (int d = 0; d < 3; d++) begin
            int          dep = (d == 2) ? 300 : 512;
            int          lat = (d == 1) ? 2 : 1;
            logic [31:0] full = (d == 2) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            logic [3:0]  wl = (d == 2) ? w : (w & 4'b0011);
            logic [31:0] bm = {{8{wl[3]}}, {8{wl[2]}}, {8{wl[1]}}, {8{wl[0]}}};
            logic        inr = int'(a) < dep;
            logic [31:0] old = inr ? mdl[d][a] : 32'h0;
            logic [31:0] nw = (old & ~bm) | (di & bm & full);
            if (wl != 0 && inr) mdl[d][a] = nw;
            if (wl == 0 || d == 1) sb.push_back('{d, cyc + lat, old});
            else if (d == 2) sb.push_back('{d, cyc + lat, inr ? nw : 32'h0});
        end
    endtask

    task automatic clear_run(input bit poke);
        int n = 0, na = 0, nb = 0, nc = 0;
        while ((busy_a || busy_b || busy_c) && n < 2000) begin
            na += int'(busy_a);
            nb += int'(busy_b);
            nc += int'(busy_c);
            if (poke && n == 100) begin
                en = 1'b1; we = 4'hF; addr = 9'd20; DI = 32'hFFFF_FFFF;
            end
            if (poke && n == 101) begin
                en = 1'b0; we = 4'h0;
            end
            n++;
            @(negedge CLK);
        end
        chk("clr_len_a", na, 512);
        chk("clr_len_b", nb, 512);
        chk("clr_len_c", nc, 300);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            for (int d = 0; d < 3; d++) if (vld[d]) begin
                int k = -1;
                for (int j = 0; j < sb.size(); j++) if (sb[j].id == d) begin
                    k = j;
                    break;
                end
                chk($sformatf("expected_strobe%0d", d), 32'(k >= 0), 32'd1);
                if (k >= 0) begin
                    chk($sformatf("do%0d", d), dout[d], sb[k].v);
                    chk($sformatf("lat%0d", d), cyc, sb[k].t);
                    sb.delete(k);
                end
            end
            for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].t < cyc) begin
                chk($sformatf("missing_strobe%0d", sb[j].id), cyc, sb[j].t);
                sb.delete(j);
            end
        end
    end

    initial begin
        RST = 1'b1; en = 1'b0; we = 4'h0; addr = 9'h0; DI = 32'h0;
        zero_model();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_do_a", dout[0], 32'h0);
        chk("rst_vld_a", 32'(vld_a), 32'h0);
        chk("rst_busy_a", 32'(busy_a), 32'h1);
        @(negedge CLK);
        RST = 1'b0;
        clear_run(1'b0);
        acc(1, 4'h0, 9'd0, 0);
        acc(1, 4'h0, 9'd100, 0);
        acc(1, 4'h0, 9'd511, 0);
        acc(1, 4'h3, 9'd5, 32'hABCD);
        acc(1, 4'h1, 9'd5, 32'h0012);
        acc(1, 4'h0, 9'd5, 0);
        acc(1, 4'h3, 9'd7, 32'h1111);
        acc(1, 4'h0, 9'd7, 0);
        acc(1, 4'h2, 9'd7, 32'h2222);
        acc(0, 4'h0, 9'd0, 0);
        acc(0, 4'h0, 9'd0, 0);
        chk("nochg_hold_a", dout[0], 32'h1111);
        acc(1, 4'h0, 9'd7, 0);
        for (int j = 1; j <= 3; j++) acc(1, 4'h3, 9'(j), 32'(j));
        for (int j = 1; j <= 3; j++) acc(1, 4'h0, 9'(j), 0);
        acc(1, 4'h0, 9'd1, 0);
        acc(0, 4'h0, 9'd0, 0);
        acc(1, 4'h0, 9'd2, 0);
        acc(1, 4'h3, 9'd9, 32'h5A5A_C3C3);
        acc(1, 4'h0, 9'd9, 0);
        repeat (60) begin
            int a = ($urandom_range(0, 1) != 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(290, 310));
            acc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 9'(a), $urandom);
        end
        acc(1, 4'hF, 9'd400, 32'h1234_5678);
        acc(1, 4'h0, 9'd400, 0);
        repeat (4) acc(0, 4'h0, 9'd0, 0);
        chk("drain1", sb.size(), 0);
        acc(1, 4'h0, 9'd5, 0);
        acc(1, 4'h0, 9'd5, 0);
        en = 1'b0;
        @(posedge CLK);
        #2;
        RST = 1'b1;
        sb.delete();
        #1;
        chk("async_do_a", dout[0], 32'h0);
        chk("async_vld_a", 32'(vld_a), 32'h0);
        chk("async_do_b", dout[1], 32'h0);
        chk("async_vld_b", 32'(vld_b), 32'h0);
        chk("async_busy_c", 32'(busy_c), 32'h1);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (200) @(negedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("restart_busy_a", 32'(busy_a), 32'h1);
        @(negedge CLK);
        RST = 1'b0;
        clear_run(1'b1);
        zero_model();
        acc(1, 4'h0, 9'd20, 0);
        acc(1, 4'h0, 9'd5, 0);
        acc(1, 4'h0, 9'd7, 0);
        repeat (4) acc(0, 4'h0, 9'd0, 0);
        chk("drain2", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/singleport_bram_bytewe_multimode.md
SINGLEPORT_BRAM_BYTEWE_MULTIMODE -- requirements
Module: singleport_bram_bytewe_multimode

Interface
REQ-001 Parameter DEPTH, default 512: number of words.
REQ-002 Parameter ADDR_WIDTH, default 9: address width; DEPTH <= 2**ADDR_WIDTH.
REQ-003 Parameter BYTE_WIDTH, default 8: bits per byte lane.
REQ-004 Parameter NUM_BYTES, default 2: byte lanes per word; word width W = NUM_BYTES*BYTE_WIDTH.
REQ-005 Parameter WRITE_MODE, default 0: 0 = no-change, 1 = read-first, 2 = write-first.
REQ-006 Parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-007 Parameter CLEAR_ON_RESET, default 1: 1 = zero-fill the array after reset.
REQ-008 CLK  input  1  sole clock; all state updates on rising edge.
REQ-009 RST  input  1  reset, asynchronous, active-high.
REQ-010 en  input  1  access enable; no read or write when low.
REQ-011 we  input  NUM_BYTES  per-lane write enable; bit i covers DI[(i+1)*BYTE_WIDTH-1 : i*BYTE_WIDTH].
REQ-012 addr  input  ADDR_WIDTH  word address.
REQ-013 DI  input  W  write data.
REQ-014 DO  output  W  read data.
REQ-015 DO_valid  output  1  one-cycle strobe marking a new DO value.
REQ-016 busy  output  1  high while the clear sequence runs; accesses ignored.

Function
REQ-017 Access accepted only when en=1 and busy=0; otherwise array, DO and DO_valid updates suppressed (DO holds, DO_valid=0).
REQ-018 Accepted write with we[i]=1 stores lane i of DI at addr; lanes with we[i]=0 keep prior contents.
REQ-019 we=0 on accepted access = pure read: DO = mem[addr] after latency L = 1+OUT_REG cycles, DO_valid=1 in the same cycle.
REQ-020 Any we bit set, WRITE_MODE=0: DO holds previous value, no DO_valid strobe.
REQ-021 Any we bit set, WRITE_MODE=1: DO = full word before the write, DO_valid after L cycles.
REQ-022 Any we bit set, WRITE_MODE=2: DO lane i = DI lane i if we[i], else old lane i; DO_valid after L cycles.
REQ-023 addr >= DEPTH: writes dropped; read/read-first/write-first returns all-zero DO with DO_valid after L cycles.
REQ-024 Back-to-back accepted accesses every cycle fully pipelined; throughput one access per cycle.
REQ-025 Read of an address written in the previous cycle returns the updated word.
REQ-026 FSM states: CLEAR, IDLE; CLEAR writes zero to addresses 0..DEPTH-1, one per cycle, busy=1; after address DEPTH-1 -> IDLE, busy=0 on the next edge.
REQ-027 Clear duration exactly DEPTH cycles from first rising edge after RST deasserts.
REQ-028 CLEAR_ON_RESET=0: reset enters IDLE directly; array contents undefined until written; busy stays 0.
REQ-029 With OUT_REG=1, en=0 in a cycle does not stall the in-flight stage; pending result still emerges with DO_valid.

Reset
REQ-030 RST asserted: DO=0, DO_valid=0, pipeline valid bits cleared, clear counter=0, immediately (no clock needed).
REQ-031 RST asserted: FSM -> CLEAR if CLEAR_ON_RESET=1 (busy=1 during reset), else IDLE.
REQ-032 RST during CLEAR restarts clear at address 0; RST mid-access discards in-flight results.
REQ-033 Memory array itself not reset directly; zeroing only through the CLEAR sequence.

Structure
REQ-034 Shared package holds WRITE_MODE constants (WM_NO_CHANGE=0, WM_READ_FIRST=1, WM_WRITE_FIRST=2) and FSM state encoding.
REQ-035 One sub-module bram_byte_lane (one lane: storage, lane write, mode-dependent read mux), instantiated NUM_BYTES times by generate; control FSM, output register and valid pipeline in the top.
REQ-036 Array coded for block-RAM inference; no combinational read of the array to outputs.

Verification
REQ-037 Defaults, reset then wait: busy=1 exactly 512 cycles; then read addr 0, 100, 511 -> DO=16'h0000, DO_valid one cycle later.
REQ-038 Write addr 5 DI=16'hABCD we=2'b11, then we=2'b01 DI=16'h0012 -> read addr 5 gives 16'hAB12.
REQ-039 WRITE_MODE=0/1/2, mem[7]=16'h1111, write we=2'b10 DI=16'h2222 -> DO: held/no strobe; 16'h1111; 16'h2211.
REQ-040 OUT_REG=1, reads addr 1,2,3 on consecutive cycles (mem=1,2,3) -> DO=1,2,3 on cycles 2,3,4 with DO_valid high each.
REQ-041 RST pulsed at clear address 200 -> counter restarts, busy high 512 more cycles; en=1 write during busy leaves addr unchanged.
REQ-042 DEPTH=300, ADDR_WIDTH=9, NUM_BYTES=4: write addr 400 ignored, read addr 400 -> DO=32'h0, DO_valid=1.
